// File: rtl/pkt_dispatch_rr.sv
// pkt_dispatch_rr: whole-packet round-robin dispatch to C_NUM_QUEUES caches, with matching one-hot PHV queue tags.
// Define PKT_DISPATCH_SKIP_BUSY_EN so that a new packet skips queues that are not ready.
module pkt_dispatch_rr #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_QUEUES         = 4,
  parameter int PKT_HDR_LEN          = 2304,
  parameter int C_QTAG_LSB           = 141,
  parameter int C_QID_FIFO_DEPTH     = 8
) (
  input  logic                              axis_clk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic                              m_axis_tlast,
  output logic [C_NUM_QUEUES-1:0]           m_axis_tvalid,
  input  logic [C_NUM_QUEUES-1:0]           m_axis_tready,
  input  logic [PKT_HDR_LEN-1:0]            phv_in,
  input  logic                              phv_in_valid,
  output logic                              phv_in_ready,
  output logic [PKT_HDR_LEN-1:0]            phv_out,
  output logic                              phv_out_valid,
  input  logic                              phv_out_ready
);
  localparam int QW = $clog2(C_NUM_QUEUES);
  localparam int AW = $clog2(C_QID_FIFO_DEPTH);
  typedef enum logic {IDLE, PKT} state_t;
  state_t state_q, state_d;
  logic [QW-1:0] rr_q, rr_d, sel_q, sel_d, cand, port;
  logic [QW-1:0] qmem_q [C_QID_FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic [PKT_HDR_LEN-1:0] phv_q, phv_d;
  logic phv_vld_q, phv_vld_d, qid_full, qid_empty, sop_ok, beat, push, pop;

  function automatic logic [QW-1:0] qadd(input logic [QW-1:0] q, input int n);
    int s;
    s = int'(q) + n;
    if (s >= C_NUM_QUEUES) s -= C_NUM_QUEUES;
    return s[QW-1:0];
  endfunction

`ifdef PKT_DISPATCH_SKIP_BUSY_EN
  // Descending scan so the nearest ready queue after rr_q wins.
  always_comb begin
    cand = rr_q;
    for (int i = C_NUM_QUEUES - 1; i >= 0; i--)
      if (m_axis_tready[qadd(rr_q, i)]) cand = qadd(rr_q, i);
  end
`else
  assign cand = rr_q;
`endif

  assign port          = (state_q == PKT) ? sel_q : cand;
  assign qid_empty     = wr_q == rd_q;
  assign qid_full      = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  // A full queue-id FIFO only holds back packet starts, never mid-packet beats.
  assign sop_ok        = (state_q == PKT) | ~qid_full;
  assign s_axis_tready = aresetn & sop_ok & m_axis_tready[port];
  assign m_axis_tvalid = (aresetn & s_axis_tvalid & sop_ok) ? C_NUM_QUEUES'(1) << port : '0;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tlast  = s_axis_tlast;
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign push          = beat & (state_q == IDLE);
  assign phv_in_ready  = ~qid_empty & (~phv_vld_q | phv_out_ready);
  assign pop           = phv_in_valid & phv_in_ready;
  assign phv_out       = phv_q;
  assign phv_out_valid = phv_vld_q;

  always_comb begin
    state_d   = beat ? (s_axis_tlast ? IDLE : PKT) : state_q;
    sel_d     = push ? cand : sel_q;
    rr_d      = push ? qadd(cand, 1) : rr_q;
    phv_vld_d = pop | (phv_vld_q & ~phv_out_ready);
    phv_d     = pop ? phv_in : phv_q;
    if (pop) phv_d[C_QTAG_LSB +: C_NUM_QUEUES] = C_NUM_QUEUES'(1) << qmem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge axis_clk or negedge aresetn)
    if (!aresetn) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      sel_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      phv_q     <= '0;
      phv_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      sel_q     <= sel_d;
      wr_q      <= wr_q + (AW+1)'(push);
      rd_q      <= rd_q + (AW+1)'(pop);
      phv_q     <= phv_d;
      phv_vld_q <= phv_vld_d;
    end

  always_ff @(posedge axis_clk)
    if (push) qmem_q[wr_q[AW-1:0]] <= cand;
endmodule

// File: tb/tb_pkt_dispatch_rr.sv
// tb_pkt_dispatch_rr: directed and random stimulus checked against a queue-based reference model.
module tb_pkt_dispatch_rr;
  localparam int NQ = 4, DW = 256, UW = 128, HL = 2304, LSB = 141, DEPTH = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] s_tdata, m_tdata;
  logic [UW-1:0] s_tuser, m_tuser;
  logic [DW/8-1:0] s_tkeep, m_tkeep;
  logic s_tvalid, s_tlast, s_tready, m_tlast;
  logic [NQ-1:0] m_tvalid, m_tready;
  logic [HL-1:0] phv_in, phv_out;
  logic phv_in_valid, phv_in_ready, phv_out_valid, phv_out_ready;
  int checks = 0, errors = 0;
  logic [1:0] m_rr, m_sel;
  bit m_in_pkt, m_vld, acc, popped, seen_tr, seen_pr;
  logic [1:0] m_qids[$];
  logic [HL-1:0] m_phv;
  logic [NQ-1:0] seen_tv;

  always #5 clk = ~clk;

  pkt_dispatch_rr dut (
    .axis_clk(clk), .aresetn(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tkeep(s_tkeep),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tkeep(m_tkeep),
    .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .phv_in(phv_in), .phv_in_valid(phv_in_valid), .phv_in_ready(phv_in_ready),
    .phv_out(phv_out), .phv_out_valid(phv_out_valid), .phv_out_ready(phv_out_ready)
  );

  task automatic chk(input string tag, input logic [HL-1:0] got, input logic [HL-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (low 256 bits)", tag, got[255:0], exp[255:0]);
    end
  endtask

  function automatic logic [HL-1:0] rbits();
    logic [HL-1:0] r;
    for (int i = 0; i < HL / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic mreset();
    m_rr = 0;
    m_sel = 0;
    m_in_pkt = 0;
    m_qids.delete();
    m_phv = '0;
    m_vld = 0;
  endtask

  // Queue chosen for a new packet: rr pointer, or the first ready queue from it when skipping is on.
  function automatic logic [1:0] pick();
    logic [1:0] idx;
`ifdef PKT_DISPATCH_SKIP_BUSY_EN
    for (int k = 0; k < NQ; k++) begin
      idx = 2'((int'(m_rr) + k) % NQ);
      if (m_tready[idx]) return idx;
    end
`endif
    idx = m_rr;
    return idx;
  endfunction

  task automatic cyc();
    logic [1:0] port, q;
    bit ok, beat, pop, pr;
    logic [NQ-1:0] ev;
    @(negedge clk);
    if (!rst_n) mreset();
    port = m_in_pkt ? m_sel : pick();
    ok = m_in_pkt || m_qids.size() < DEPTH;
    beat = rst_n && ok && m_tready[port] && s_tvalid;
    ev = (rst_n && s_tvalid && ok) ? NQ'(1) << port : '0;
    pr = m_qids.size() > 0 && (!m_vld || phv_out_ready);
    pop = pr && phv_in_valid;
    seen_tv = m_tvalid;
    seen_tr = s_tready;
    seen_pr = phv_in_ready;
    chk("s_axis_tready", HL'(s_tready), HL'(rst_n && ok && m_tready[port]));
    chk("m_axis_tvalid", HL'(m_tvalid), HL'(ev));
    chk("phv_in_ready", HL'(phv_in_ready), HL'(pr));
    chk("phv_out_valid", HL'(phv_out_valid), HL'(m_vld));
    chk("phv_out", phv_out, m_phv);
    chk("m_axis_tdata", HL'(m_tdata), HL'(s_tdata));
    chk("m_axis_side", HL'({m_tuser, m_tkeep, m_tlast}), HL'({s_tuser, s_tkeep, s_tlast}));
    @(posedge clk);
    acc = beat;
    popped = pop;
    if (rst_n) begin
      if (pop) begin
        q = m_qids.pop_front();
        m_phv = phv_in;
        m_phv[LSB +: NQ] = NQ'(1) << q;
        m_vld = 1;
      end else if (phv_out_ready) m_vld = 0;
      if (beat && !m_in_pkt) begin
        m_qids.push_back(port);
        m_sel = port;
        m_rr = 2'((int'(port) + 1) % NQ);
      end
      if (beat) m_in_pkt = !s_tlast;
    end
    #1;
  endtask

  task automatic beat_send(input bit last);
    s_tvalid = 1;
    s_tlast = last;
    s_tdata = DW'(rbits());
    s_tuser = UW'(rbits());
    s_tkeep = 32'($urandom);
    acc = 0;
    for (int n = 0; n < 40 && !acc; n++) cyc();
    chk("beat_accepted", HL'(acc), HL'(1'b1));
  endtask

  task automatic send_pkt(input int len);
    for (int b = 0; b < len; b++) beat_send(b == len - 1);
    s_tvalid = 0;
  endtask

  task automatic send_phv();
    phv_in = rbits();
    phv_in_valid = 1;
    popped = 0;
    for (int n = 0; n < 40 && !popped; n++) cyc();
    phv_in_valid = 0;
    chk("phv_accepted", HL'(popped), HL'(1'b1));
  endtask

  task automatic do_reset();
    rst_n = 0;
    cyc();
    rst_n = 1;
  endtask

  initial begin
    mreset();
    s_tvalid = 1; s_tlast = 0; s_tdata = '0; s_tuser = '0; s_tkeep = '0;
    m_tready = '1; phv_in = '0; phv_in_valid = 0; phv_out_ready = 1;
    repeat (2) cyc();
    chk("rst_tvalid", HL'(m_tvalid), '0);
    chk("rst_tready", HL'(s_tready), '0);
    chk("rst_phv_out", phv_out, '0);
    rst_n = 1;
    s_tvalid = 0;
    // Single-beat packets go 0,1,2,3 and PHV tags follow.
    for (int i = 0; i < 4; i++) begin
      send_pkt(1);
      chk("t1_tvalid", HL'(seen_tv), HL'(NQ'(1) << i));
    end
    for (int i = 0; i < 4; i++) begin
      send_phv();
      chk("t1_tag", HL'(phv_out[LSB +: NQ]), HL'(NQ'(1) << i));
    end
    // Backpressure on queue 0 mid-packet.
    beat_send(0);
    chk("t2_q0", HL'(seen_tv), HL'(4'b0001));
    s_tdata = DW'(rbits());
    m_tready = 4'b1110;
    repeat (5) begin
      cyc();
      chk("t2_stall", HL'(seen_tr), '0);
    end
    m_tready = '1;
    beat_send(0);
    beat_send(1);
    s_tvalid = 0;
    send_pkt(1);
    chk("t2_next_q1", HL'(seen_tv), HL'(4'b0010));
    send_phv();
    chk("t2_tag0", HL'(phv_out[LSB +: NQ]), HL'(4'b0001));
    send_phv();
    chk("t2_tag1", HL'(phv_out[LSB +: NQ]), HL'(4'b0010));
    // Queue-id FIFO fills at 8 packets.
    do_reset();
    repeat (8) send_pkt(1);
    s_tvalid = 1; s_tlast = 1;
    repeat (3) begin
      cyc();
      chk("t3_full", HL'(seen_tr), '0);
    end
    phv_in = rbits();
    phv_in_valid = 1;
    cyc();
    phv_in_valid = 0;
    beat_send(1);
    s_tvalid = 0;
    chk("t3_9th_q0", HL'(seen_tv), HL'(4'b0001));
    for (int i = 1; i <= 8; i++) begin
      send_phv();
      chk("t3_tag", HL'(phv_out[LSB +: NQ]), HL'(NQ'(1) << (i % NQ)));
    end
    // Downstream PHV stall holds the output and blocks intake.
    phv_out_ready = 0;
    send_pkt(1);
    send_pkt(1);
    phv_in = rbits();
    phv_in_valid = 1;
    repeat (3) begin
      cyc();
      chk("t4_in_ready", HL'(seen_pr), '0);
      chk("t4_hold_tag", HL'(phv_out[LSB +: NQ]), HL'(4'b0001));
    end
    phv_out_ready = 1;
    cyc();
    chk("t4_load_same_cycle", HL'(seen_pr), HL'(1'b1));
    chk("t4_new_tag", HL'(phv_out[LSB +: NQ]), HL'(4'b0010));
    phv_in_valid = 0;
    send_phv();
    chk("t4_tag2", HL'(phv_out[LSB +: NQ]), HL'(4'b0100));
    // Busy queue at packet start.
    do_reset();
    send_pkt(1);
    send_phv();
    chk("t5_tag_first", HL'(phv_out[LSB +: NQ]), HL'(4'b0001));
    m_tready = 4'b1101;
    s_tvalid = 1; s_tlast = 1; s_tdata = DW'(rbits());
    cyc();
`ifdef PKT_DISPATCH_SKIP_BUSY_EN
    chk("t5_skip_tvalid", HL'(seen_tv), HL'(4'b0100));
    chk("t5_skip_tready", HL'(seen_tr), HL'(1'b1));
`else
    chk("t5_wait_tvalid", HL'(seen_tv), HL'(4'b0010));
    chk("t5_wait_tready", HL'(seen_tr), '0);
    repeat (3) cyc();
    m_tready = '1;
    cyc();
    chk("t5_late_tvalid", HL'(seen_tv), HL'(4'b0010));
    chk("t5_late_tready", HL'(seen_tr), HL'(1'b1));
`endif
    s_tvalid = 0;
    m_tready = '1;
    send_pkt(1);
`ifdef PKT_DISPATCH_SKIP_BUSY_EN
    chk("t5_next_q3", HL'(seen_tv), HL'(4'b1000));
`else
    chk("t5_next_q2", HL'(seen_tv), HL'(4'b0100));
`endif
    send_phv();
    send_phv();
    // Reset during beat 2 of a 4-beat packet.
    beat_send(0);
    s_tdata = DW'(rbits());
    rst_n = 0;
    cyc();
    chk("t6_tvalid", HL'(m_tvalid), '0);
    chk("t6_fifo_empty", HL'(phv_in_ready), '0);
    chk("t6_phv_valid", HL'(phv_out_valid), '0);
    rst_n = 1;
    beat_send(0);
    chk("t6_sop_q0", HL'(seen_tv), HL'(4'b0001));
    beat_send(0);
    beat_send(1);
    s_tvalid = 0;
    send_phv();
    chk("t6_tag", HL'(phv_out[LSB +: NQ]), HL'(4'b0001));
    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom % 600) != 0;
      s_tvalid = ($urandom % 4) != 0;
      s_tlast = ($urandom % 3) == 0;
      s_tdata = DW'(rbits());
      s_tuser = UW'(rbits());
      s_tkeep = 32'($urandom);
      m_tready = NQ'($urandom | $urandom);
      phv_in_valid = ($urandom % 2) != 0;
      if (phv_in_valid) phv_in = rbits();
      phv_out_ready = ($urandom % 4) != 0;
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pkt_dispatch_rr.md
Name: pkt_dispatch_rr

Overview:
- Packet-level distributor between the ingress AXI-Stream and C_NUM_QUEUES packet cache FIFOs.
- Each whole packet is sent to one queue. The chosen queue id is recorded in an internal queue-id FIFO.
- The parser's PHV stream is then stamped with a matching one-hot queue tag, so the deparser fetches the payload from the correct cache.
- Replaces fixed four-queue, free-running-counter tagging; payload and PHV stay consistent even when queues are skipped.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, stream data width.
- C_S_AXIS_TUSER_WIDTH, 128, stream tuser width.
- C_NUM_QUEUES, 4, number of output packet queues (2..16).
- PKT_HDR_LEN, 2304, PHV width.
- C_QTAG_LSB, 141, LSB of the one-hot queue tag field inside the PHV (C_QTAG_LSB + C_NUM_QUEUES <= PKT_HDR_LEN).
- C_QID_FIFO_DEPTH, 8, depth of the queue-id FIFO (power of 2).

Ports:
- axis_clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  ingress data
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  ingress tuser
- s_axis_tkeep  in  C_S_AXIS_DATA_WIDTH/8  ingress byte enables
- s_axis_tvalid  in  1  ingress valid
- s_axis_tlast  in  1  ingress end of packet
- s_axis_tready  out  1  ingress ready
- m_axis_tdata  out  C_S_AXIS_DATA_WIDTH  shared egress data, wire copy of s_axis_tdata
- m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH  shared egress tuser
- m_axis_tkeep  out  C_S_AXIS_DATA_WIDTH/8  shared egress keep
- m_axis_tlast  out  1  shared egress last
- m_axis_tvalid  out  C_NUM_QUEUES  per-queue valid, at most one bit set
- m_axis_tready  in  C_NUM_QUEUES  per-queue ready
- phv_in  in  PKT_HDR_LEN  PHV from parser
- phv_in_valid  in  1  PHV valid
- phv_in_ready  out  1  PHV accepted
- phv_out  out  PKT_HDR_LEN  tagged PHV
- phv_out_valid  out  1  tagged PHV valid
- phv_out_ready  in  1  downstream stage ready

Behaviour:
- Clocking and reset: single clock axis_clk. aresetn is asynchronous, active-low.
- Reset state: state=IDLE, rr_ptr=0, sel=0, queue-id FIFO empty, phv_out=0, phv_out_valid=0. All m_axis_tvalid bits and s_axis_tready are 0 during reset.
- Packet FSM, IDLE:
  - cand = rr_ptr.
  - sop_ok = !qid_full.
  - m_axis_tvalid[cand] = s_axis_tvalid & sop_ok.
  - s_axis_tready = sop_ok & m_axis_tready[cand].
  - On an accepted beat: push cand into the queue-id FIFO; sel <= cand; rr_ptr <= cand+1, wrapping C_NUM_QUEUES-1 -> 0.
  - If tlast on that beat: remain IDLE (single-beat packet). Otherwise go to PKT.
- Packet FSM, PKT:
  - m_axis_tvalid[sel] = s_axis_tvalid.
  - s_axis_tready = m_axis_tready[sel].
  - An accepted beat with tlast returns the FSM to IDLE. No pointer change in PKT.
- Data path: m_axis_t{data,user,keep,last} are zero-latency combinational pass-through. Packets are never split across queues.
- Queue-id FIFO:
  - Width clog2(C_NUM_QUEUES), depth C_QID_FIFO_DEPTH.
  - When full, no new packet starts; s_axis_tready stays 0 in IDLE.
  - Mid-packet beats are never blocked by a full FIFO.
  - A push at SOP and a PHV pop may occur in the same cycle. Occupancy is unchanged.
- PHV path:
  - phv_in_ready = !qid_empty & (!phv_out_valid | phv_out_ready).
  - On phv_in_valid & phv_in_ready: pop qid; phv_out <= phv_in with bits [C_QTAG_LSB +: C_NUM_QUEUES] replaced by (1<<qid); phv_out_valid <= 1. Latency is 1 cycle.
  - All other PHV bits pass unchanged.
  - phv_out_valid clears on phv_out_ready when no new PHV is loaded in the same cycle.
  - A PHV arriving before its packet SOP waits (phv_in_ready=0).
- Reset mid-packet: FSM returns to IDLE and the FIFO is flushed. The remainder of the packet is accepted as a new packet.

Optional Feature:
- Macro: PKT_DISPATCH_SKIP_BUSY_EN.
- Defined: in IDLE, cand = first queue with m_axis_tready=1, searched circularly starting at rr_ptr. If none is ready, cand = rr_ptr. rr_ptr <= cand+1 after SOP. Busy queues are skipped, so distribution is no longer strictly round-robin.
- Undefined: strict round-robin; IDLE waits on queue rr_ptr.

Test Plan:
- Reset, then 4 single-beat packets, all readies=1 -> m_axis_tvalid one-hot 0001,0010,0100,1000. Four PHVs get tags 0001,0010,0100,1000 at bits [141+:4], each 1 cycle after acceptance.
- 3-beat packet to queue 0; deassert m_axis_tready[0] on beat 2 for 5 cycles -> s_axis_tready=0 for those cycles; no beat lost or duplicated; next packet goes to queue 1.
- Send 8 packets with phv_in_valid=0 (FIFO full at depth 8) -> 9th SOP stalls with s_axis_tready=0. Then 1 PHV accepted -> 9th packet starts same or next cycle, to queue 0.
- phv_out_ready=0 with phv_out_valid=1 -> phv_in_ready=0 and phv_out held stable. Release -> next PHV loads in the same cycle.
- With PKT_DISPATCH_SKIP_BUSY_EN, rr_ptr=1, m_axis_tready=1101 -> packet goes to queue 2, rr_ptr=3, PHV tag 0100. Without the macro -> stalls until m_axis_tready[1]=1.
- Assert aresetn=0 during beat 2 of a 4-beat packet -> m_axis_tvalid=0, FIFO empty, phv_out_valid=0. After release the first SOP goes to queue 0.
